ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/ex_div.sv | 68 ++++++
 rtl/ex_stage.sv | 158 +++++++++++++++
 tb/tb_ex_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcodes, exception/memory/control encodings and the EX register layout
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_OP_NOP  = 4'h0,
        ALU_OP_AND  = 4'h1,
        ALU_OP_OR   = 4'h2,
        ALU_OP_XOR  = 4'h3,
        ALU_OP_ADDS = 4'h4,
        ALU_OP_ADDU = 4'h5,
        ALU_OP_SUBS = 4'h6,
        ALU_OP_SUBU = 4'h7,
        ALU_OP_SHRL = 4'h8,
        ALU_OP_SHLL = 4'h9,
        ALU_OP_DIVU = 4'hA,
        ALU_OP_REMU = 4'hB
    } alu_op_t;

    localparam logic [2:0] EXP_NO_EXP     = 3'h0;
    localparam logic [2:0] EXP_UNDEF_INSN = 3'h1;
    localparam logic [2:0] EXP_OVERFLOW   = 3'h2;

    localparam logic [1:0] MEM_OP_NOP = 2'h0;
    localparam logic [1:0] MEM_OP_LDW = 2'h1;
    localparam logic [1:0] MEM_OP_STW = 2'h2;

    localparam logic [1:0] CTRL_OP_NOP  = 2'h0;
    localparam logic [1:0] CTRL_OP_WRCR = 2'h1;
    localparam logic [1:0] CTRL_OP_EXRT = 2'h2;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'h0,
        DIV_BUSY = 2'h1,
        DIV_DONE = 2'h2
    } div_state_t;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic [1:0]  mem_op;
        logic [31:0] mem_wr_data;
        logic [31:0] out;
        logic        br_flag;
        logic [1:0]  ctrl_op;
        logic [4:0]  dst_addr;
        logic        gpr_we_;
        logic [2:0]  exp_code;
    } ex_reg_t;

    // an invalid slot that writes nothing; pc is the only field callers choose
    function automatic ex_reg_t bubble(input logic [29:0] pc);
        bubble         = '0;
        bubble.pc      = pc;
        bubble.gpr_we_ = 1'b1;
    endfunction

endpackage

// File: rtl/ex_div.sv
// ex_div: 32-iteration restoring unsigned divider with IDLE/BUSY/DONE control
module ex_div
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        done
);
    div_state_t  state, state_nx;
    logic [4:0]  cnt;
    logic [31:0] q, d;
    logic [32:0] r, r_sh;
    logic        ge;

    assign r_sh = {r[31:0], q[31]};
    assign ge   = r_sh >= {1'b0, d};

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= DIV_IDLE;
        else        state <= state_nx;
    end

    // next state: flush aborts from anywhere, DONE waits for a non-stalled edge
    always_comb begin
        state_nx = flush                                           ? DIV_IDLE :
                   (state == DIV_IDLE && start)                    ? DIV_BUSY :
                   (state == DIV_BUSY && cnt == 5'(DIV_ITER - 1))  ? DIV_DONE :
                   (state == DIV_DONE && !stall)                   ? DIV_IDLE : state;
    end

    // outputs decoded from state
    always_comb begin
        busy = state != DIV_IDLE;
        done = state == DIV_DONE;
    end

    // operand capture and one shift-subtract step per BUSY cycle; divisor 0 naturally gives all-ones / dividend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= '0;
            d   <= '0;
            r   <= '0;
        end else if (state == DIV_IDLE && start) begin
            cnt <= '0;
            q   <= dividend;
            d   <= divisor;
            r   <= '0;
        end else if (state == DIV_BUSY) begin
            cnt <= cnt + 5'd1;
            q   <= {q[30:0], ge};
            r   <= ge ? r_sh - {1'b0, d} : r_sh;
        end
    end

    assign quotient  = q;
    assign remainder = r[31:0];

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with inline ALU and EX/MEM register; EX_DIVIDER_EN adds DIVU/REMU via ex_div
module ex_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    input  logic [29:0] id_pc,
    input  logic        id_en,
    input  logic [3:0]  id_alu_op,
    input  logic [31:0] id_alu_in_0,
    input  logic [31:0] id_alu_in_1,
    input  logic        id_br_flag,
    input  logic [1:0]  id_mem_op,
    input  logic [31:0] id_mem_wr_data,
    input  logic [1:0]  id_ctrl_op,
    input  logic [4:0]  id_dst_addr,
    input  logic        id_gpr_we_,
    input  logic [2:0]  id_exp_code,
    output logic [29:0] ex_pc,
    output logic        ex_en,
    output logic [1:0]  ex_mem_op,
    output logic [31:0] ex_mem_wr_data,
    output logic [31:0] ex_out,
    output logic        ex_br_flag,
    output logic [1:0]  ex_ctrl_op,
    output logic [4:0]  ex_dst_addr,
    output logic        ex_gpr_we_,
    output logic [2:0]  ex_exp_code,
    output logic [31:0] ex_fwd_data
);
    ex_reg_t     cur, nxt;
    logic [31:0] alu_out, sum, diff, div_res;
    logic        ovf, is_div, undef, div_busy, div_done, div_we_;
    logic [29:0] div_pc;
    logic [4:0]  div_dst;

    assign sum    = id_alu_in_0 + id_alu_in_1;
    assign diff   = id_alu_in_0 - id_alu_in_1;
    assign is_div = id_alu_op == ALU_OP_DIVU || id_alu_op == ALU_OP_REMU;
    assign ovf    = (id_alu_op == ALU_OP_ADDS && id_alu_in_0[31] == id_alu_in_1[31] && sum[31] != id_alu_in_0[31]) ||
                    (id_alu_op == ALU_OP_SUBS && id_alu_in_0[31] != id_alu_in_1[31] && diff[31] != id_alu_in_0[31]);

    // single-cycle ALU result, also forwarded to decode
    always_comb begin
        case (id_alu_op)
            ALU_OP_AND:               alu_out = id_alu_in_0 & id_alu_in_1;
            ALU_OP_OR:                alu_out = id_alu_in_0 | id_alu_in_1;
            ALU_OP_XOR:               alu_out = id_alu_in_0 ^ id_alu_in_1;
            ALU_OP_ADDS, ALU_OP_ADDU: alu_out = sum;
            ALU_OP_SUBS, ALU_OP_SUBU: alu_out = diff;
            ALU_OP_SHRL:              alu_out = id_alu_in_0 >> id_alu_in_1[4:0];
            ALU_OP_SHLL:              alu_out = id_alu_in_0 << id_alu_in_1[4:0];
            default:                  alu_out = '0;
        endcase
    end

    assign ex_fwd_data = alu_out;

`ifdef EX_DIVIDER_EN
    logic [31:0] quo, rem;
    logic        div_start, is_rem;

    assign div_start = id_en && is_div && !flush;
    assign undef     = 1'b0;
    assign div_res   = is_rem ? rem : quo;
    assign busy      = div_busy;

    ex_div u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .stall     (stall),
        .flush     (flush),
        .dividend  (id_alu_in_0),
        .divisor   (id_alu_in_1),
        .quotient  (quo),
        .remainder (rem),
        .busy      (div_busy),
        .done      (div_done)
    );

    // remember the accepted divide's destination while upstream is held off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_pc  <= '0;
            div_dst <= '0;
            div_we_ <= 1'b1;
            is_rem  <= 1'b0;
        end else if (div_start && !div_busy) begin
            div_pc  <= id_pc;
            div_dst <= id_dst_addr;
            div_we_ <= id_gpr_we_;
            is_rem  <= id_alu_op == ALU_OP_REMU;
        end
    end
`else
    assign undef    = is_div;
    assign div_busy = 1'b0;
    assign div_done = 1'b0;
    assign div_res  = '0;
    assign div_pc   = '0;
    assign div_dst  = '0;
    assign div_we_  = 1'b1;
    assign busy     = 1'b0;
`endif

    // next register contents: flush > stall > divider > bubble > normal issue
    always_comb begin
        nxt = cur;
        if (flush) nxt = bubble('0);
        else if (stall) nxt = cur;
        else if (div_done) begin
            nxt          = bubble(div_pc);
            nxt.en       = 1'b1;
            nxt.out      = div_res;
            nxt.dst_addr = div_dst;
            nxt.gpr_we_  = div_we_;
        end
        else if (div_busy) nxt = bubble('0);
        else if (!id_en) nxt = bubble(id_pc);
        else begin
            nxt = '{pc: id_pc, en: 1'b1, mem_op: id_mem_op, mem_wr_data: id_mem_wr_data, out: alu_out,
                    br_flag: id_br_flag, ctrl_op: id_ctrl_op, dst_addr: id_dst_addr,
                    gpr_we_: id_gpr_we_, exp_code: id_exp_code};
            if (ovf || undef) begin
                nxt.mem_op   = MEM_OP_NOP;
                nxt.ctrl_op  = CTRL_OP_NOP;
                nxt.br_flag  = 1'b0;
                nxt.gpr_we_  = 1'b1;
                nxt.exp_code = undef ? EXP_UNDEF_INSN : EXP_OVERFLOW;
            end
`ifdef EX_DIVIDER_EN
            if (is_div) nxt = bubble(id_pc);
`endif
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= bubble('0);
        else        cur <= nxt;
    end

    assign ex_pc          = cur.pc;
    assign ex_en          = cur.en;
    assign ex_mem_op      = cur.mem_op;
    assign ex_mem_wr_data = cur.mem_wr_data;
    assign ex_out         = cur.out;
    assign ex_br_flag     = cur.br_flag;
    assign ex_ctrl_op     = cur.ctrl_op;
    assign ex_dst_addr    = cur.dst_addr;
    assign ex_gpr_we_     = cur.gpr_we_;
    assign ex_exp_code    = cur.exp_code;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed checks of ex_stage ALU, exceptions, stall/flush, reset and (with EX_DIVIDER_EN) the divider
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n, stall, flush, busy;
    logic [29:0] id_pc, ex_pc;
    logic        id_en, id_br_flag, id_gpr_we_, ex_en, ex_br_flag, ex_gpr_we_;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0, id_alu_in_1, id_mem_wr_data, ex_mem_wr_data, ex_out, ex_fwd_data;
    logic [1:0]  id_mem_op, id_ctrl_op, ex_mem_op, ex_ctrl_op;
    logic [4:0]  id_dst_addr, ex_dst_addr;
    logic [2:0]  id_exp_code, ex_exp_code;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .busy(busy),
        .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
        .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
        .id_br_flag(id_br_flag), .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
        .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
        .id_exp_code(id_exp_code),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
        .ex_out(ex_out), .ex_br_flag(ex_br_flag), .ex_ctrl_op(ex_ctrl_op),
        .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code),
        .ex_fwd_data(ex_fwd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        id_en       = 1'b1;
        id_alu_op   = op;
        id_alu_in_0 = a;
        id_alu_in_1 = b;
    endtask

    initial begin
        int  n;
        logic seen;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        id_pc = '0; id_en = 1'b0; id_alu_op = '0; id_alu_in_0 = '0; id_alu_in_1 = '0;
        id_br_flag = 1'b0; id_mem_op = '0; id_mem_wr_data = '0; id_ctrl_op = '0;
        id_dst_addr = '0; id_gpr_we_ = 1'b1; id_exp_code = '0;
        repeat (2) step();
        chk("rst_en", 32'(ex_en), 0);
        chk("rst_out", ex_out, 0);
        chk("rst_pc", 32'(ex_pc), 0);
        chk("rst_we", 32'(ex_gpr_we_), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_exp", 32'(ex_exp_code), 0);
        rst_n = 1'b1;

        // ADDU wraps without exception, side-band fields pass through
        issue(4'h5, 32'hFFFF_FFFF, 32'h1);
        id_pc = 30'h100; id_gpr_we_ = 1'b0; id_dst_addr = 5'd5; id_mem_op = 2'h1; id_mem_wr_data = 32'hCAFE_0001;
        #1 chk("addu_fwd", ex_fwd_data, 0);
        step();
        chk("addu_out", ex_out, 0);
        chk("addu_exp", 32'(ex_exp_code), 0);
        chk("addu_we", 32'(ex_gpr_we_), 0);
        chk("addu_en", 32'(ex_en), 1);
        chk("addu_pc", 32'(ex_pc), 32'h100);
        chk("addu_memop", 32'(ex_mem_op), 1);
        chk("addu_wdata", ex_mem_wr_data, 32'hCAFE_0001);
        chk("addu_dst", 32'(ex_dst_addr), 5);

        // ADDS overflow kills side effects but result and pc still load
        issue(4'h4, 32'h7FFF_FFFF, 32'h1);
        id_pc = 30'h101; id_mem_op = 2'h2; id_ctrl_op = 2'h1; id_br_flag = 1'b1;
        step();
        chk("adds_out", ex_out, 32'h8000_0000);
        chk("adds_exp", 32'(ex_exp_code), 2);
        chk("adds_we", 32'(ex_gpr_we_), 1);
        chk("adds_memop", 32'(ex_mem_op), 0);
        chk("adds_ctrl", 32'(ex_ctrl_op), 0);
        chk("adds_br", 32'(ex_br_flag), 0);
        chk("adds_pc", 32'(ex_pc), 32'h101);

        // SUBS overflow vs SUBU on the same operands
        issue(4'h6, 32'h8000_0000, 32'h1);
        step();
        chk("subs_out", ex_out, 32'h7FFF_FFFF);
        chk("subs_exp", 32'(ex_exp_code), 2);
        issue(4'h7, 32'h8000_0000, 32'h1);
        step();
        chk("subu_exp", 32'(ex_exp_code), 0);
        chk("subu_ctrl", 32'(ex_ctrl_op), 1);
        chk("subu_br", 32'(ex_br_flag), 1);
        id_mem_op = 2'h0; id_ctrl_op = 2'h0; id_br_flag = 1'b0;

        // ADDS without overflow: negative plus positive
        issue(4'h4, 32'hFFFF_FFFE, 32'h5);
        step();
        chk("adds_ok_out", ex_out, 32'h3);
        chk("adds_ok_exp", 32'(ex_exp_code), 0);

        // logic ops and shifts (only b[4:0] used as shift amount)
        issue(4'h1, 32'hF0F0_1234, 32'h0FF0_FF00); step(); chk("and", ex_out, 32'h00F0_1200);
        issue(4'h2, 32'hF0F0_1234, 32'h0FF0_FF00); step(); chk("or", ex_out, 32'hFFF0_FF34);
        issue(4'h3, 32'hF0F0_1234, 32'h0FF0_FF00); step(); chk("xor", ex_out, 32'hFF00_ED34);
        issue(4'h8, 32'h8000_0000, 32'h24);        step(); chk("shrl", ex_out, 32'h0800_0000);
        issue(4'h0, 32'h1234_5678, 32'h1);         step(); chk("nop", ex_out, 0);

        // stall holds the register for 3 cycles; forwarding still follows inputs
        issue(4'h9, 32'h1, 32'h4); id_pc = 30'h200;
        step();
        chk("shll_out", ex_out, 16);
        stall = 1'b1;
        issue(4'h5, 32'h1, 32'h1); id_pc = 30'h201;
        #1 chk("stall_fwd", ex_fwd_data, 2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_out", ex_out, 16);
            chk("stall_pc", 32'(ex_pc), 32'h200);
        end
        flush = 1'b1;
        step();
        chk("flush_en", 32'(ex_en), 0);
        chk("flush_out", ex_out, 0);
        chk("flush_pc", 32'(ex_pc), 0);
        chk("flush_we", 32'(ex_gpr_we_), 1);
        stall = 1'b0; flush = 1'b0;

        // id_en low: bubble but pc still loads
        issue(4'h5, 32'h3, 32'h4); id_en = 1'b0; id_pc = 30'h55;
        step();
        chk("noen_en", 32'(ex_en), 0);
        chk("noen_pc", 32'(ex_pc), 32'h55);
        chk("noen_out", ex_out, 0);
        chk("noen_we", 32'(ex_gpr_we_), 1);

`ifndef EX_DIVIDER_EN
        issue(4'hA, 32'd100, 32'd7); id_gpr_we_ = 1'b0;
        step();
        chk("divu_undef_exp", 32'(ex_exp_code), 1);
        chk("divu_undef_we", 32'(ex_gpr_we_), 1);
        chk("divu_undef_busy", 32'(busy), 0);
        issue(4'hB, 32'd100, 32'd7);
        step();
        chk("remu_undef_exp", 32'(ex_exp_code), 1);
        chk("remu_undef_busy", 32'(busy), 0);
        id_en = 1'b0;
`else
        // four divides: {op, a, b, expected}
        for (int k = 0; k < 4; k++) begin
            logic [3:0]  op;
            logic [31:0] a, b, req;
            case (k)
                0: begin op = 4'hA; a = 32'd100; b = 32'd7; req = 32'd14;        end
                1: begin op = 4'hB; a = 32'd100; b = 32'd7; req = 32'd2;         end
                2: begin op = 4'hA; a = 32'd5;   b = 32'd0; req = 32'hFFFF_FFFF; end
                default: begin op = 4'hB; a = 32'd5; b = 32'd0; req = 32'd5;     end
            endcase
            issue(op, a, b); id_pc = 30'(32'h300 + k); id_dst_addr = 5'd9; id_gpr_we_ = 1'b0;
            step();
            id_en = 1'b0; id_alu_op = 4'h0;
            n = 0; seen = 1'b0;
            while (busy && n < 40) begin
                seen = seen | ex_en;
                n++;
                step();
            end
            chk("div_busy_cycles", 32'(n), 33);
            chk("div_no_early_en", 32'(seen), 0);
            chk("div_out", ex_out, req);
            chk("div_en", 32'(ex_en), 1);
            chk("div_pc", 32'(ex_pc), 32'h300 + k);
            chk("div_we", 32'(ex_gpr_we_), 0);
            chk("div_exp", 32'(ex_exp_code), 0);
        end

        // flush at iteration 10 aborts
        issue(4'hA, 32'd100, 32'd7);
        step();
        id_en = 1'b0;
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_div_busy", 32'(busy), 0);
        chk("flush_div_en", 32'(ex_en), 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin step(); seen = seen | ex_en | busy; end
        chk("flush_div_stale", 32'(seen), 0);

        // asynchronous reset mid-divide aborts
        issue(4'hB, 32'd100, 32'd7);
        step();
        id_en = 1'b0;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1 chk("rst_div_busy", 32'(busy), 0);
        chk("rst_div_en", 32'(ex_en), 0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin step(); seen = seen | ex_en | busy; end
        chk("rst_div_stale", 32'(seen), 0);
`endif

        // reset pulse returns register to reset state
        issue(4'h5, 32'd1, 32'd2); id_gpr_we_ = 1'b0;
        step();
        chk("pre_rst_out", ex_out, 3);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_out", ex_out, 0);
        chk("async_rst_we", 32'(ex_gpr_we_), 1);
        step();
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
